// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer for a word-wide single-port DRAM without byte enables.
// One access in flight; sub-word stores are read-modify-write; all outputs registered.
module mem_access_ctrl #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misalign,
  output logic              busy,
  output logic [ADDR_W-1:0] dram_addr,
  output logic              dram_we,
  output logic [31:0]       dram_wdata,
  input  logic [31:0]       dram_rdata
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        op_we, op_we_nxt;
  logic [1:0]  op_size, op_size_nxt;
  logic        op_uns, op_uns_nxt;
  logic [1:0]  op_off, op_off_nxt;
  logic [31:0] op_wdata, op_wdata_nxt;

  logic [ADDR_W-1:0] dram_addr_nxt;
  logic              dram_we_nxt;
  logic [31:0]       dram_wdata_nxt;
  logic              resp_valid_nxt;
  logic [31:0]       resp_rdata_nxt;
  logic              resp_misalign_nxt;

  logic accept;
  logic misalign;
  logic unused_addr_bits;

  assign accept   = req_valid & req_ready;
  assign misalign = ((req_size == 2'b01) & req_addr[0]) |
                    (req_size[1] & (req_addr[1:0] != 2'b00));
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  // size: 1x word, 01 half, 00 byte
  function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [1:0] sz,
                                               input logic [1:0] off, input logic uns);
    logic [3:0][7:0]  b;
    logic [1:0][15:0] h;
    logic [7:0]       bv;
    logic [15:0]      hv;
    b  = rd;
    h  = rd;
    bv = b[off];
    hv = h[off[1]];
    if (sz[1])      return rd;
    else if (sz[0]) return {{16{hv[15] & ~uns}}, hv};
    else            return {{24{bv[7] & ~uns}}, bv};
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] rd, input logic [1:0] sz,
                                              input logic [1:0] off, input logic [31:0] wd);
    logic [3:0][7:0]  b;
    logic [1:0][15:0] h;
    b = rd;
    h = rd;
    b[off]    = wd[7:0];
    h[off[1]] = wd[15:0];
    if (sz[0]) return h;
    else       return b;
  endfunction

  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    op_we_nxt         = op_we;
    op_size_nxt       = op_size;
    op_uns_nxt        = op_uns;
    op_off_nxt        = op_off;
    op_wdata_nxt      = op_wdata;
    dram_addr_nxt     = dram_addr;
    dram_we_nxt       = 1'b0;
    dram_wdata_nxt    = dram_wdata;
    resp_valid_nxt    = 1'b0;
    resp_rdata_nxt    = '0;
    resp_misalign_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          op_we_nxt     = req_we;
          op_size_nxt   = req_size;
          op_uns_nxt    = req_unsigned;
          op_off_nxt    = req_addr[1:0];
          op_wdata_nxt  = req_wdata;
          dram_addr_nxt = req_addr[ADDR_W+1:2];
          if (misalign) begin
            state_nxt         = RESP;
            resp_valid_nxt    = 1'b1;
            resp_misalign_nxt = 1'b1;
          end else if (req_we && req_size[1]) begin
            state_nxt      = WRITE;
            dram_we_nxt    = 1'b1;
            dram_wdata_nxt = req_wdata;
          end else begin
            state_nxt = RD_WAIT;
            cnt_nxt   = 3'(RD_LAT);
          end
        end
      end
      RD_WAIT: begin
        // counter reaches 0 in the cycle dram_rdata is valid for our address
        if (cnt == 3'd0) begin
          if (op_we) begin
            state_nxt      = WRITE;
            dram_we_nxt    = 1'b1;
            dram_wdata_nxt = store_merge(dram_rdata, op_size, op_off, op_wdata);
          end else begin
            state_nxt      = RESP;
            resp_valid_nxt = 1'b1;
            resp_rdata_nxt = load_extract(dram_rdata, op_size, op_off, op_uns);
          end
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      WRITE: begin
        state_nxt      = RESP;
        resp_valid_nxt = 1'b1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      op_we         <= 1'b0;
      op_size       <= '0;
      op_uns        <= 1'b0;
      op_off        <= '0;
      op_wdata      <= '0;
      req_ready     <= 1'b0;
      busy          <= 1'b0;
      dram_addr     <= '0;
      dram_we       <= 1'b0;
      dram_wdata    <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_misalign <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      op_we         <= op_we_nxt;
      op_size       <= op_size_nxt;
      op_uns        <= op_uns_nxt;
      op_off        <= op_off_nxt;
      op_wdata      <= op_wdata_nxt;
      req_ready     <= (state_nxt == IDLE);
      busy          <= (state_nxt != IDLE);
      dram_addr     <= dram_addr_nxt;
      dram_we       <= dram_we_nxt;
      dram_wdata    <= dram_wdata_nxt;
      resp_valid    <= resp_valid_nxt;
      resp_rdata    <= resp_rdata_nxt;
      resp_misalign <= resp_misalign_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (RD_LAT 1 and 3) share one request stream,
// each with its own DRAM model; results are compared against an arithmetic reference.
module tb_mem_access_ctrl;
  localparam int ADDR_W = 16;

  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b1;
  always #5 cpu_clk = ~cpu_clk;

  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size  = '0;
  logic [31:0] req_addr  = '0, req_wdata = '0;

  logic [1:0]             req_ready, resp_valid, resp_misalign, busy, dram_we;
  logic [1:0][31:0]       resp_rdata, dram_wdata, dram_rdata, rb_data;
  logic [1:0][ADDR_W-1:0] dram_addr;

  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0, rb_idx = '0;
  logic [31:0] pl_val = '0;

  int total = 0;
  int bad   = 0;
  logic [31:0] ref_mem [256];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem  [256];
    logic [31:0] pipe [LAT];

    mem_access_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(LAT)) u_dut (
      .cpu_clk      (cpu_clk),
      .cpu_rst      (cpu_rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready[g]),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid[g]),
      .resp_rdata   (resp_rdata[g]),
      .resp_misalign(resp_misalign[g]),
      .busy         (busy[g]),
      .dram_addr    (dram_addr[g]),
      .dram_we      (dram_we[g]),
      .dram_wdata   (dram_wdata[g]),
      .dram_rdata   (dram_rdata[g])
    );

    // DRAM: address sampled on an edge, data valid LAT cycles later
    always @(posedge cpu_clk) begin
      if (pl_en) mem[pl_idx] <= pl_val;
      else if (dram_we[g]) mem[dram_addr[g][7:0]] <= dram_wdata[g];
      pipe[0] <= mem[dram_addr[g][7:0]];
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign dram_rdata[g] = pipe[LAT-1];
    assign rb_data[g]    = mem[rb_idx];
  end

  task automatic chk(input string tag, input int lane, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[lat%0d]: got %h expected %h", tag, (lane == 0) ? 1 : 3, obs, exp);
    end
  endtask

  // Reference: result, new memory word and event cycles (relative to accept edge = 0)
  function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] old,
                                input int lat, output logic mis, output logic [31:0] rd,
                                output logic [31:0] newv, output int resp_c, output int we_c);
    int off, sh;
    logic [31:0] mask, v;
    off  = int'(a % 4);
    mis  = (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && off != 0);
    rd   = '0;
    newv = old;
    we_c = 0;
    if (sz == 2'd1) begin sh = 16 * (off / 2); mask = 32'hFFFF; end
    else            begin sh = 8 * off;        mask = 32'hFF;   end
    if (mis) resp_c = 1;
    else if (we && sz >= 2'd2) begin
      newv = wd; we_c = 1; resp_c = 2;
    end else if (we) begin
      newv = (old & ~(mask << sh)) | ((wd & mask) << sh);
      we_c = lat + 2; resp_c = lat + 3;
    end else begin
      resp_c = lat + 2;
      if (sz >= 2'd2) rd = old;
      else begin
        v = (old >> sh) & mask;
        if (!uns && v > (mask >> 1)) v = v | ~mask;
        rd = v;
      end
    end
  endfunction

  task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    int          idx;
    int          resp_c [2], we_n [2], we_c [2], e_resp, e_we;
    logic [31:0] rdv [2], wdv [2], wav [2], e_rd, e_new;
    logic        misv [2], done [2], e_mis;
    idx = int'(a[9:2]);
    for (int i = 0; i < 2; i++) begin
      resp_c[i] = 0; we_n[i] = 0; we_c[i] = 0; rdv[i] = '0; wdv[i] = '0; wav[i] = '0;
      misv[i] = 1'b0; done[i] = 1'b0;
    end
    @(negedge cpu_clk);
    for (int i = 0; i < 2; i++) begin
      chk("idle_ready", i, 32'(req_ready[i]), 32'd1);
      chk("idle_resp", i, 32'(resp_valid[i]), 32'd0);
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    @(negedge cpu_clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!done[i]) begin
          chk("busy", i, 32'(busy[i]), 32'd1);
          chk("dram_addr", i, 32'(dram_addr[i]), 32'(a[17:2]));
          if (dram_we[i]) begin
            we_n[i]++; we_c[i] = c; wdv[i] = dram_wdata[i]; wav[i] = 32'(dram_addr[i]);
          end
          if (resp_valid[i]) begin
            resp_c[i] = c; rdv[i] = resp_rdata[i]; misv[i] = resp_misalign[i]; done[i] = 1'b1;
          end
        end
      end
      if (done[0] && done[1]) break;
      @(negedge cpu_clk);
    end
    rb_idx = idx[7:0];
    #1;
    for (int i = 0; i < 2; i++) begin
      model(we, sz, uns, a, wd, ref_mem[idx], (i == 0) ? 1 : 3, e_mis, e_rd, e_new, e_resp, e_we);
      chk("resp_cycle", i, 32'(resp_c[i]), 32'(e_resp));
      chk("resp_rdata", i, rdv[i], e_rd);
      chk("resp_misalign", i, 32'(misv[i]), 32'(e_mis));
      chk("we_count", i, 32'(we_n[i]), (e_we != 0) ? 32'd1 : 32'd0);
      if (e_we != 0) begin
        chk("we_cycle", i, 32'(we_c[i]), 32'(e_we));
        chk("we_data", i, wdv[i], e_new);
        chk("we_addr", i, wav[i], 32'(a[17:2]));
      end
      chk("mem_word", i, rb_data[i], e_new);
    end
    model(we, sz, uns, a, wd, ref_mem[idx], 1, e_mis, e_rd, e_new, e_resp, e_we);
    ref_mem[idx] = e_new;
  endtask

  initial begin
    int          nwe [2], nresp [2];
    logic [1:0]  sz;
    logic [31:0] a, v;

    // preload both DRAMs and the reference while the controllers sit in reset
    for (int i = 0; i < 256; i++) begin
      v = (i == 8'h40) ? 32'h8899AABB : $urandom;
      @(negedge cpu_clk);
      pl_en = 1'b1; pl_idx = 8'(i); pl_val = v; ref_mem[i] = v;
    end
    @(negedge cpu_clk);
    pl_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", i, 32'(req_ready[i]), 32'd0);
      chk("rst_busy", i, 32'(busy[i]), 32'd0);
      chk("rst_resp", i, 32'(resp_valid[i]), 32'd0);
      chk("rst_rdata", i, resp_rdata[i], 32'd0);
      chk("rst_mis", i, 32'(resp_misalign[i]), 32'd0);
      chk("rst_we", i, 32'(dram_we[i]), 32'd0);
      chk("rst_addr", i, 32'(dram_addr[i]), 32'd0);
      chk("rst_wdata", i, dram_wdata[i], 32'd0);
    end
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    for (int i = 0; i < 2; i++) begin
      chk("post_rst_ready", i, 32'(req_ready[i]), 32'd1);
      chk("post_rst_busy", i, 32'(busy[i]), 32'd0);
    end

    // directed accesses around word 0x40 = 0x8899AABB
    access(1'b0, 2'd0, 1'b0, 32'h101, 32'h0);
    access(1'b0, 2'd0, 1'b1, 32'h101, 32'h0);
    access(1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
    access(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
    access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    access(1'b1, 2'd0, 1'b0, 32'h103, 32'h12345677);
    access(1'b1, 2'd2, 1'b0, 32'h100, 32'h8899AABB);
    access(1'b1, 2'd1, 1'b0, 32'h100, 32'h0000CAFE);
    access(1'b1, 2'd2, 1'b0, 32'h104, 32'hDEADBEEF);
    access(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    access(1'b1, 2'd1, 1'b0, 32'h103, 32'h5555AAAA);
    access(1'b1, 2'd2, 1'b0, 32'h100, 32'h8899AABB);
    access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);

    // half store abandoned by a reset taking effect on the edge into cycle 2
    for (int i = 0; i < 2; i++) begin nwe[i] = 0; nresp[i] = 0; end
    @(negedge cpu_clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h0000F00D;
    @(negedge cpu_clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (dram_we[i]) nwe[i]++;
        if (resp_valid[i]) nresp[i]++;
        if (c == 3) chk("ready_after_rst", i, 32'(req_ready[i]), 32'd1);
      end
      if (c == 1) cpu_rst = 1'b1;
      if (c == 2) cpu_rst = 1'b0;
      @(negedge cpu_clk);
    end
    rb_idx = 8'h40;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("abort_we", i, 32'(nwe[i]), 32'd0);
      chk("abort_resp", i, 32'(nresp[i]), 32'd0);
      chk("abort_mem", i, rb_data[i], ref_mem[8'h40]);
    end
    access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);

    // random traffic, mostly aligned
    for (int n = 0; n < 150; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (sz[1]) a[1:0] = 2'b00;
        else if (sz[0]) a[0] = 1'b0;
      end
      access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

MEM-stage load/store sequencer between the pipeline and a word-wide, single-port data DRAM with no byte enables. It accepts one access at a time and reads the DRAM with a fixed latency. Loads are returned lane-selected and sign- or zero-extended. Byte and half-word stores run as read-modify-write. The pipeline is stalled while the access is in flight.

## Interface
- `ADDR_W`, 16: DRAM word-address width.
- `RD_LAT`, 1: cycles from `dram_addr` sampled by DRAM to `dram_rdata` valid; legal 1..4.

- `cpu_clk`  in  1  clock, rising edge.
- `cpu_rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  access request.
- `req_ready`  out  1  controller idle; request accepted on edge with `req_valid & req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `req_unsigned`  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for word and stores.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; byte uses [7:0], half uses [15:0].
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and misaligned accesses.
- `resp_misalign`  out  1  valid with `resp_valid`; access aborted.
- `busy`  out  1  stall to pipeline; equals `~req_ready`.
- `dram_addr`  out  ADDR_W  word address = `req_addr[ADDR_W+1:2]`, held stable for the whole access.
- `dram_we`  out  1  write strobe, at most one cycle per access.
- `dram_wdata`  out  32  write data.
- `dram_rdata`  in  32  read data.

## Operation
- All outputs are registered.
- Reset values: state IDLE, `req_ready`=0 while `cpu_rst` is high and 1 in the first cycle after; all other outputs 0.
- IDLE: `req_ready`=1. On accept, latch the request and run the misalign check:
  - half with `addr[0]`=1, or word with `addr[1:0]`≠0, goes to RESP with `resp_misalign`=1 and no DRAM access;
  - aligned word store goes to WRITE with `dram_wdata`=`req_wdata`;
  - any other access (loads, sub-word stores) goes to RD_WAIT with counter = `RD_LAT`.
- RD_WAIT: `dram_addr` is driven. The counter decrements each cycle. In the cycle where the counter is 0, `dram_rdata` is captured. Loads then go to RESP; sub-word stores go to WRITE.
- Load extract:
  - byte = `rdata >> 8*addr[1:0]`, bits [7:0];
  - half = `rdata >> 16*addr[1]`, bits [15:0];
  - extended to 32 bits per `req_unsigned`; word passes through.
- Store merge: byte replaces bits [8k+7:8k] (k = `addr[1:0]`) with `wdata[7:0]`; half replaces bits [16h+15:16h] (h = `addr[1]`) with `wdata[15:0]`. All other bits keep the read value.
- WRITE: `dram_we`=1 for exactly one cycle with merged or full data, then go to RESP.
- RESP: `resp_valid`=1 for one cycle, `req_ready`=0, then return to IDLE. Requests are accepted only in IDLE, so back-to-back accesses are separated by at least this cycle.
- Reset mid-operation: the access is abandoned and nothing is written after the reset edge. A `dram_we` already driven in the cycle where reset is asserted completes. No `resp_valid` is produced for an abandoned access.

## Timing
Cycle 0 is the accept edge.
- Misaligned: RESP in cycle 1.
- Word store: WRITE in cycle 1, RESP in cycle 2.
- Load: RD_WAIT in cycles 1..`RD_LAT`+1, RESP in cycle `RD_LAT`+2.
- Sub-word store: RD_WAIT in cycles 1..`RD_LAT`+1, WRITE in cycle `RD_LAT`+2, RESP in cycle `RD_LAT`+3.
- `busy` is high from cycle 1 through RESP inclusive.
- `dram_addr` changes only on an accept edge.

## Test plan
DRAM word 0x40 (byte 0x100) = 0x8899AABB, `RD_LAT`=1 unless noted.
- LB 0x101 signed -> `resp_rdata`=0xFFFFFFAA with `resp_valid` in cycle 3. LBU 0x101 -> 0x000000AA. `dram_we` never asserted.
- LH 0x102 signed -> 0xFFFF8899. LHU 0x102 -> 0x00008899. LW 0x100 -> 0x8899AABB.
- SB 0x103 `wdata`=0x12345677 -> `dram_we` only in cycle 3 with `dram_wdata`=0x7799AABB, `resp_valid` in cycle 4. SH 0x100 `wdata`=0x0000CAFE -> 0x8899CAFE.
- SW 0x104 0xDEADBEEF -> `dram_we` in cycle 1 with `dram_addr`=0x41, `resp_valid` in cycle 2.
- LW 0x102 and SH 0x103 -> `resp_valid` and `resp_misalign`=1 in cycle 1, `resp_rdata`=0, no `dram_we`, memory unchanged.
- `RD_LAT`=3, SH 0x100 with reset pulsed in cycle 2 -> no `dram_we`, no `resp_valid`, `req_ready`=1 the cycle after reset drops. A following LW 0x100 returns 0x8899AABB in cycle 5.
